// File: rtl/alu_ctrl_pkg.sv
// Shared widths and FSM encoding for the two-requester ALU arbiter.
package alu_ctrl_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int OP_W_DEF   = 8;
  localparam int FLAG_W_DEF = 5;
  localparam int NUM_REQ    = 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  function automatic logic [NUM_REQ-1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, response and shared-ALU signals of the arbiter.
interface alu_arbiter_if import alu_ctrl_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF,
  parameter int FLAG_W = FLAG_W_DEF
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ*OP_W-1:0]   req_op;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]         rsp_c;
  logic [FLAG_W-1:0]         rsp_flags;
  logic [DATA_W-1:0]         alu_a;
  logic [DATA_W-1:0]         alu_b;
  logic [OP_W-1:0]           alu_opcode;
  logic [DATA_W-1:0]         alu_c;
  logic [FLAG_W-1:0]         alu_flags;

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready, alu_c, alu_flags,
    output req_ready, rsp_valid, rsp_c, rsp_flags, alu_a, alu_b, alu_opcode
  );

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready, alu_c, alu_flags,
    input  req_ready, rsp_valid, rsp_c, rsp_flags, alu_a, alu_b, alu_opcode
  );
endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, on contention
// the one that did not win last time goes.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] gnt
);
  assign gnt[0] = valid[0] & (~valid[1] |  last);
  assign gnt[1] = valid[1] & (~valid[0] | ~last);
endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: accept, one EXEC
// cycle to capture the ALU result, then hold the response until taken.
module alu_arbiter import alu_ctrl_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF,
  parameter int FLAG_W = FLAG_W_DEF
) (
  input logic           clk,
  input logic           rst_n,
  alu_arbiter_if.slave  bus
);

  logic [1:0]        state;
  logic              owner;
  logic              last_grant;
  logic [DATA_W-1:0] rsp_c_q;
  logic [FLAG_W-1:0] rsp_flags_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic [OP_W-1:0]   alu_op_q;

  logic [NUM_REQ-1:0]             gnt;
  logic [NUM_REQ-1:0]             ready;
  logic                           hs;
  logic [NUM_REQ-1:0][DATA_W-1:0] a_vec, b_vec;
  logic [NUM_REQ-1:0][OP_W-1:0]   op_vec;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign a_vec[i]  = bus.req_a[i*DATA_W +: DATA_W];
    assign b_vec[i]  = bus.req_b[i*DATA_W +: DATA_W];
    assign op_vec[i] = bus.req_op[i*OP_W +: OP_W];
  end

  rr_arb2 u_arb (
    .valid (bus.req_valid),
    .last  (last_grant),
    .gnt   (gnt)
  );

  // Grant is only offered in IDLE; rst_n gates it so nothing is accepted
  // while reset is held.
  assign ready = (rst_n && state == S_IDLE) ? gnt : '0;
  assign hs    = |(bus.req_valid & ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      rsp_c_q     <= '0;
      rsp_flags_q <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
    end else begin
      case (state)
        S_IDLE: if (hs) begin
          alu_a_q    <= a_vec[gnt[1]];
          alu_b_q    <= b_vec[gnt[1]];
          alu_op_q   <= op_vec[gnt[1]];
          owner      <= gnt[1];
          last_grant <= gnt[1];
          state      <= S_EXEC;
        end
        S_EXEC: begin
          rsp_c_q     <= bus.alu_c;
          rsp_flags_q <= bus.alu_flags;
          state       <= S_RESP;
        end
        S_RESP: if (bus.rsp_ready[owner]) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = ready;
  assign bus.rsp_valid  = (state == S_RESP) ? onehot2(owner) : '0;
  assign bus.rsp_c      = rsp_c_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_opcode = alu_op_q;

`ifndef SYNTHESIS
  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.req_ready));
  a_rsp_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.rsp_valid));
  a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (state == S_RESP && !bus.rsp_ready[owner]) |=>
      ($stable(rsp_c_q) && $stable(rsp_flags_q) && state == S_RESP));
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench: directed table, multi-cycle corner sequences and a
// randomized run against a transaction-level model of the arbiter.
module tb_alu_arbiter;
  import alu_ctrl_pkg::*;

  localparam int DW = 16;
  localparam int OW = 8;
  localparam int FW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  alu_arbiter_if #(.DATA_W(DW), .OP_W(OW), .FLAG_W(FW)) bus ();

  alu_arbiter #(.DATA_W(DW), .OP_W(OW), .FLAG_W(FW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference ALU; flags = {parity, overflow(add), negative, carry, zero}.
  function automatic logic [20:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [7:0] op);
    logic [16:0] s;
    logic [15:0] c;
    logic        v;
    case (op)
      8'd0:    s = {1'b0, a} + {1'b0, b};
      8'd1:    s = {1'b0, a} - {1'b0, b};
      8'd2:    s = {1'b0, a & b};
      8'd3:    s = {1'b0, a | b};
      8'd4:    s = {1'b0, a ^ b};
      default: s = {1'b0, a ^ {op, op}};
    endcase
    c = s[15:0];
    v = (op == 8'd0) && (a[15] == b[15]) && (c[15] != a[15]);
    return {^c, v, c[15], s[16], c == 16'd0, c};
  endfunction

  always_comb {bus.alu_flags, bus.alu_c} = alu_f(bus.alu_a, bus.alu_b, bus.alu_opcode);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int r, input logic [15:0] a, input logic [15:0] b,
                         input logic [7:0] op);
    bus.req_a[r*DW +: DW] = a;
    bus.req_b[r*DW +: DW] = b;
    bus.req_op[r*OW +: OW] = op;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  // One isolated operation from requester r, checking grant, latency and result.
  task automatic run_single(input int r, input logic [15:0] a, input logic [15:0] b,
                            input logic [7:0] op, input logic [15:0] ec, input logic [4:0] ef);
    logic [1:0] oh;
    oh = (r == 1) ? 2'b10 : 2'b01;
    set_req(r, a, b, op);
    bus.req_valid = oh;
    #1 chk("single_ready", 32'(bus.req_ready), 32'(oh));
    tick();
    bus.req_valid = 2'b00;
    #1 chk("single_exec_novalid", 32'(bus.rsp_valid), 0);
    chk("single_opcode_pass", 32'(bus.alu_opcode), 32'(op));
    tick();
    #1 chk("single_rsp_valid", 32'(bus.rsp_valid), 32'(oh));
    chk("single_rsp_c", 32'(bus.rsp_c), 32'(ec));
    chk("single_rsp_flags", 32'(bus.rsp_flags), 32'(ef));
    tick();
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  op;
    logic [15:0] c;
    logic [4:0]  f;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // model state for the random phase
    logic [1:0]  mv, eg, erv;
    logic [15:0] ma[2], mb[2];
    logic [7:0]  mop[2];
    logic [20:0] pres;
    bit          pend, powner, mlast, hs;
    int          age, issued, got, lastc;

    tbl[0] = '{16'd5,     16'd3,      8'd0,    16'h0008, 5'b10000};
    tbl[1] = '{16'd5,     16'hFFF9,   8'd0,    16'hFFFE, 5'b10100};
    tbl[2] = '{16'hFFFF,  16'h0001,   8'd0,    16'h0000, 5'b00011};
    tbl[3] = '{16'h7FFF,  16'h0001,   8'd0,    16'h8000, 5'b11100};
    tbl[4] = '{16'd3,     16'd5,      8'd1,    16'hFFFE, 5'b10110};
    tbl[5] = '{16'hF0F0,  16'h3C3C,   8'd2,    16'h3030, 5'b00000};
    tbl[6] = '{16'hAAAA,  16'h5555,   8'd4,    16'hFFFF, 5'b00100};
    tbl[7] = '{16'h1234,  16'h0000,   8'h81,   16'h93B5, 5'b10100};

    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_op = '0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_req_ready", 32'(bus.req_ready), 0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("reset_rsp_c", 32'(bus.rsp_c), 0);
    chk("reset_rsp_flags", 32'(bus.rsp_flags), 0);
    chk("reset_alu_a", 32'(bus.alu_a), 0);
    chk("reset_alu_b", 32'(bus.alu_b), 0);
    chk("reset_alu_op", 32'(bus.alu_opcode), 0);
    bus.req_valid = 2'b00;
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++)
      run_single(i % 2, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].c, tbl[i].f);

    // contention after reset: r0 first, then r1, then r0 again
    pulse_reset();
    set_req(0, 16'd1, 16'd2, 8'd0);
    set_req(1, 16'd10, 16'd20, 8'd0);
    bus.req_valid = 2'b11;
    #1 chk("rr_first_r0", 32'(bus.req_ready), 32'(2'b01));
    tick();
    bus.req_valid = 2'b10;
    #1 chk("rr_exec_noready", 32'(bus.req_ready), 0);
    tick();
    #1 chk("rr_rsp0_valid", 32'(bus.rsp_valid), 32'(2'b01));
    chk("rr_rsp0_c", 32'(bus.rsp_c), 3);
    tick();
    #1 chk("rr_second_r1", 32'(bus.req_ready), 32'(2'b10));
    tick();
    bus.req_valid = 2'b00;
    tick();
    #1 chk("rr_rsp1_valid", 32'(bus.rsp_valid), 32'(2'b10));
    chk("rr_rsp1_c", 32'(bus.rsp_c), 30);
    tick();
    bus.req_valid = 2'b11;
    #1 chk("rr_third_r0", 32'(bus.req_ready), 32'(2'b01));
    tick();
    bus.req_valid = 2'b00;
    tick();
    tick();
    tick();

    // r1 response stalled 10 cycles while r0 waits; r0 rsp_ready is ignored
    bus.rsp_ready = 2'b01;
    set_req(1, 16'h1234, 16'd1, 8'd0);
    bus.req_valid = 2'b10;
    #1 chk("stall_r1_grant", 32'(bus.req_ready), 32'(2'b10));
    tick();
    set_req(0, 16'd4, 16'd4, 8'd0);
    bus.req_valid = 2'b01;
    #1 chk("stall_exec_noready", 32'(bus.req_ready), 0);
    tick();
    for (int k = 0; k < 10; k++) begin
      #1 chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'(2'b10));
      chk("stall_rsp_c", 32'(bus.rsp_c), 32'h1235);
      chk("stall_no_grant", 32'(bus.req_ready), 0);
      tick();
    end
    bus.rsp_ready = 2'b11;
    #1 chk("stall_release_valid", 32'(bus.rsp_valid), 32'(2'b10));
    tick();
    #1 chk("stall_r0_granted", 32'(bus.req_ready), 32'(2'b01));
    tick();
    bus.req_valid = 2'b00;
    tick();
    #1 chk("stall_r0_rsp_c", 32'(bus.rsp_c), 8);
    chk("stall_r0_rsp_valid", 32'(bus.rsp_valid), 32'(2'b01));
    tick();

    // reset during EXEC discards the operation
    set_req(0, 16'd7, 16'd9, 8'd0);
    bus.req_valid = 2'b01;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", 32'(bus.req_ready), 0);
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("midrst_rsp_c", 32'(bus.rsp_c), 0);
    chk("midrst_rsp_flags", 32'(bus.rsp_flags), 0);
    chk("midrst_alu_a", 32'(bus.alu_a), 0);
    chk("midrst_alu_b", 32'(bus.alu_b), 0);
    chk("midrst_alu_op", 32'(bus.alu_opcode), 0);
    bus.req_valid = 2'b00;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      #1 chk("midrst_no_rsp", 32'(bus.rsp_valid), 0);
    end
    tick();
    run_single(0, 16'd5, 16'hFFF9, 8'd0, 16'hFFFE, 5'b10100);

    // back-to-back stream: 32 ops, exact 3-cycle issue spacing
    bus.rsp_ready = 2'b11;
    set_req(0, 16'd0, 16'd0, 8'd0);
    bus.req_valid = 2'b01;
    issued = 0;
    got = 0;
    lastc = 0;
    for (int cyc = 0; cyc < 150 && got < 32; cyc++) begin
      #1;
      if (bus.rsp_valid[0]) begin
        chk("loop_rsp_c", 32'(bus.rsp_c), 32'(16'(4 * got)));
        got++;
      end
      hs = 1'b0;
      if (bus.req_valid[0] && bus.req_ready[0]) begin
        if (issued > 0) chk("loop_spacing", 32'(cyc - lastc), 3);
        lastc = cyc;
        issued++;
        hs = 1'b1;
      end
      tick();
      if (hs) begin
        if (issued < 32) set_req(0, 16'(issued), 16'(3 * issued), 8'd0);
        else bus.req_valid = 2'b00;
      end
    end
    chk("loop_count", 32'(got), 32);
    bus.req_valid = 2'b00;
    tick();
    tick();

    // randomized traffic against a transaction-level model
    pulse_reset();
    mv = 2'b00;
    pend = 1'b0;
    powner = 1'b0;
    mlast = 1'b1;
    age = 0;
    pres = '0;
    for (int r = 0; r < 2; r++) begin
      ma[r] = '0;
      mb[r] = '0;
      mop[r] = '0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int r = 0; r < 2; r++) begin
        if (!mv[r] && $urandom_range(0, 2) == 0) begin
          mv[r] = 1'b1;
          ma[r] = 16'($urandom);
          mb[r] = 16'($urandom);
          mop[r] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 4)) : 8'($urandom);
          set_req(r, ma[r], mb[r], mop[r]);
        end
      end
      bus.req_valid = mv;
      bus.rsp_ready = 2'($urandom_range(0, 3));
      #1;
      if (pend) eg = 2'b00;
      else if (mv == 2'b11) eg = mlast ? 2'b01 : 2'b10;
      else eg = mv;
      chk("rnd_req_ready", 32'(bus.req_ready), 32'(eg));
      erv = (pend && age >= 1) ? (powner ? 2'b10 : 2'b01) : 2'b00;
      chk("rnd_rsp_valid", 32'(bus.rsp_valid), 32'(erv));
      if (erv != 2'b00) begin
        chk("rnd_rsp_c", 32'(bus.rsp_c), 32'(pres[15:0]));
        chk("rnd_rsp_flags", 32'(bus.rsp_flags), 32'(pres[20:16]));
      end
      if (pend) begin
        if (age >= 1 && bus.rsp_ready[powner]) pend = 1'b0;
        else age++;
      end else if (eg != 2'b00) begin
        powner = eg[1];
        mlast = eg[1];
        pend = 1'b1;
        age = 0;
        pres = alu_f(ma[powner], mb[powner], mop[powner]);
        mv[powner] = 1'b0;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
